// File: rtl/wide_param_bank_if.sv
// Bus bundle for wide_param_bank: write/apply inputs, read port, and update
// notifications. The master drives the writes and the slave is the register bank.
interface wide_param_bank_if #(
    parameter int unsigned NUM_REGS = 16
);
    localparam int unsigned ADDR_W = $clog2(NUM_REGS);

    logic [15:0]       address;
    logic [63:0]       data_in;
    logic              data_available;
    logic              apply_immediately;
    logic              apply;
    logic [ADDR_W-1:0] read_index;
    logic [63:0]       read_data;
    logic              update_strobe;
    logic [ADDR_W-1:0] update_index;
    logic [63:0]       update_data;
    logic              pending;
    logic              busy;
    logic              apply_done;
    logic              addr_error;

    modport master (
        output address, data_in, data_available, apply_immediately, apply, read_index,
        input  read_data, update_strobe, update_index, update_data,
               pending, busy, apply_done, addr_error
    );

    modport slave (
        input  address, data_in, data_available, apply_immediately, apply, read_index,
        output read_data, update_strobe, update_index, update_data,
               pending, busy, apply_done, addr_error
    );
endinterface

// File: rtl/wide_param_bank.sv
// Bank of NUM_REGS 64-bit parameter registers with shadow/active copies.
// Staged writes collect in the shadow copies and are committed by an index
// sweep triggered by apply. Immediate writes go straight to the active copy.
// Every change to an active copy is announced on update_strobe.
module wide_param_bank #(
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [15:0] ADDR_BASE = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    wide_param_bank_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(NUM_REGS);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   sweep_idx;
    logic                apply_queued;
    logic [NUM_REGS-1:0] pending_bits;
    logic [63:0]         shadow [NUM_REGS];
    logic [63:0]         active [NUM_REGS];

    logic [63:0]         read_r;
    logic                upd_strobe_r;
    logic [ADDR_W-1:0]   upd_index_r;
    logic [63:0]         upd_data_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;

    logic [15:0]         idx_full;
    logic [ADDR_W-1:0]   idx;
    logic                in_range;
    logic                wr_stage;
    logic                wr_imm;
    logic                stall;
    logic                restart;

    // Address decode and write qualification.
    always_comb begin
        idx_full = bus.address - ADDR_BASE;
        idx      = idx_full[ADDR_W-1:0];
        in_range = (bus.address >= ADDR_BASE) && ({16'd0, idx_full} < NUM_REGS);
        wr_stage = bus.data_available && !bus.apply_immediately && in_range;
        wr_imm   = bus.data_available &&  bus.apply_immediately && in_range;
        stall    = (state == S_SWEEP) && wr_imm;
        restart  = apply_queued || bus.apply;
    end

    // Register bank, commit sweep FSM and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            sweep_idx    <= '0;
            apply_queued <= 1'b0;
            pending_bits <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            read_r       <= '0;
            upd_strobe_r <= 1'b0;
            upd_index_r  <= '0;
            upd_data_r   <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            upd_strobe_r <= 1'b0;
            done_r       <= 1'b0;
            read_r       <= active[bus.read_index];

            // Sweep transfer comes before the write handling so that a staged
            // write to the same index in the same cycle wins on shadow and
            // pending, while active still takes the old shadow value.
            if (state == S_SWEEP && !stall && pending_bits[sweep_idx]) begin
                active[sweep_idx]       <= shadow[sweep_idx];
                pending_bits[sweep_idx] <= 1'b0;
                upd_strobe_r            <= 1'b1;
                upd_index_r             <= sweep_idx;
                upd_data_r              <= shadow[sweep_idx];
            end

            if (bus.data_available && !in_range) begin
                err_r <= 1'b1;
            end

            if (wr_stage) begin
                shadow[idx]       <= bus.data_in;
                pending_bits[idx] <= 1'b1;
            end

            if (wr_imm) begin
                shadow[idx]       <= bus.data_in;
                active[idx]       <= bus.data_in;
                pending_bits[idx] <= 1'b0;
                upd_strobe_r      <= 1'b1;
                upd_index_r       <= idx;
                upd_data_r        <= bus.data_in;
            end

            case (state)
                S_IDLE: begin
                    if (bus.apply) begin
                        state     <= S_SWEEP;
                        sweep_idx <= '0;
                        busy_r    <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    if (bus.apply) begin
                        apply_queued <= 1'b1;
                    end
                    if (!stall) begin
                        if (&sweep_idx) begin
                            done_r       <= 1'b1;
                            sweep_idx    <= '0;
                            apply_queued <= 1'b0;
                            if (!restart) begin
                                state  <= S_IDLE;
                                busy_r <= 1'b0;
                            end
                        end else begin
                            sweep_idx <= sweep_idx + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.read_data     = read_r;
    assign bus.update_strobe = upd_strobe_r;
    assign bus.update_index  = upd_index_r;
    assign bus.update_data   = upd_data_r;
    assign bus.pending       = |pending_bits;
    assign bus.busy          = busy_r;
    assign bus.apply_done    = done_r;
    assign bus.addr_error    = err_r;
endmodule

// File: tb/tb_wide_param_bank.sv
// Directed bench for wide_param_bank with a scoreboard of expected update
// strobes and apply_done pulses, each tagged with the edge that produces it.
module tb_wide_param_bank;
    localparam int unsigned NR   = 16;
    localparam logic [15:0] BASE = 16'h0100;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wide_param_bank_if #(.NUM_REGS(NR)) bus ();

    wide_param_bank #(.NUM_REGS(NR), .ADDR_BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  idx;
        logic [63:0] data;
        int unsigned at_edge;
    } upd_t;

    upd_t        upd_q[$];
    int unsigned done_q[$];

    int unsigned cyc = 0;
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Edge counter: after posedge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every strobe/done pulse must match the queue head.
    upd_t        e;
    int unsigned d;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.update_strobe) begin
                if (upd_q.size() == 0) begin
                    check("unexpected_strobe", 64'(cyc), 64'hFFFF_FFFF);
                end else begin
                    e = upd_q.pop_front();
                    check("upd_index", 64'(bus.update_index), 64'(e.idx));
                    check("upd_data", bus.update_data, e.data);
                    check("upd_edge", 64'(cyc), 64'(e.at_edge));
                end
            end
            if (bus.apply_done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
                end else begin
                    d = done_q.pop_front();
                    check("done_edge", 64'(cyc), 64'(d));
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.data_available    = 1'b0;
        bus.apply_immediately = 1'b0;
        bus.apply             = 1'b0;
    endtask

    // Called at a negedge; the write is sampled at edge cyc+1.
    task automatic wr(input logic [15:0] a, input logic [63:0] dat, input logic imm);
        logic [15:0] off;
        upd_t        u;
        off = a - BASE;
        if (imm && a >= BASE && off < 16'(NR)) begin
            u.idx     = off[3:0];
            u.data    = dat;
            u.at_edge = cyc + 1;
            upd_q.push_back(u);
        end
        bus.address           = a;
        bus.data_in           = dat;
        bus.apply_immediately = imm;
        bus.data_available    = 1'b1;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic push_upd(input int unsigned i, input logic [63:0] dat, input int unsigned at);
        upd_t u;
        u.idx     = 4'(i);
        u.data    = dat;
        u.at_edge = at;
        upd_q.push_back(u);
    endtask

    task automatic do_apply();
        bus.apply = 1'b1;
        @(negedge clk);
        bus.apply = 1'b0;
    endtask

    task automatic rd(input int unsigned i, input logic [63:0] exp, input string tag);
        bus.read_index = 4'(i);
        @(negedge clk);
        check(tag, bus.read_data, exp);
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    localparam logic [63:0] DV = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] VA = 64'h0000_0001_AAAA_0001;
    localparam logic [63:0] VB = 64'h0000_0005_BBBB_0005;
    localparam logic [63:0] VC = 64'h0000_0002_CCCC_0002;
    localparam logic [63:0] VD = 64'h0000_000C_DDDD_000C;
    localparam logic [63:0] VF = 64'h0000_000A_FFFF_000A;
    localparam logic [63:0] VG = 64'h0000_0007_7777_0007;
    localparam logic [63:0] VH = 64'h8000_0000_0000_0000;
    localparam logic [63:0] VI = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] VJ = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] VK = 64'h0000_0004_4444_0004;

    int unsigned ev;
    int unsigned busy_cnt;

    initial begin
        bus.address    = '0;
        bus.data_in    = '0;
        bus.read_index = '0;
        idle_inputs();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_read_data", bus.read_data, 64'h0);
        check("rst_strobe", 64'(bus.update_strobe), 64'h0);
        check("rst_upd_index", 64'(bus.update_index), 64'h0);
        check("rst_upd_data", bus.update_data, 64'h0);
        check("rst_pending", 64'(bus.pending), 64'h0);
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_done", 64'(bus.apply_done), 64'h0);
        check("rst_addr_error", 64'(bus.addr_error), 64'h0);

        // Immediate write to index 3
        wr(BASE + 16'd3, DV, 1'b1);
        check("imm_pending", 64'(bus.pending), 64'h0);
        rd(3, DV, "imm_read3");

        // Staged writes to 1 and 5, then apply
        wr(BASE + 16'd1, VA, 1'b0);
        wr(BASE + 16'd5, VB, 1'b0);
        check("staged_pending", 64'(bus.pending), 64'h1);
        rd(5, 64'h0, "staged_not_active");
        ev = cyc + 1;
        push_upd(1, VA, ev + 2);
        push_upd(5, VB, ev + 6);
        done_q.push_back(ev + 16);
        do_apply();
        check("sweep_busy", 64'(bus.busy), 64'h1);
        wait_until(ev + 16);
        check("sweep_end_busy", 64'(bus.busy), 64'h0);
        check("sweep_end_pending", 64'(bus.pending), 64'h0);
        rd(5, VB, "commit_read5");
        rd(1, VA, "commit_read1");

        // Writes during a sweep, including one stall
        wr(BASE + 16'd12, VD, 1'b0);
        ev = cyc + 1;
        done_q.push_back(ev + 17);
        do_apply();
        wait_until(ev + 3);
        wr(BASE + 16'd2, VC, 1'b0);
        wr(BASE + 16'd10, VF, 1'b0);
        wr(BASE + 16'd7, VG, 1'b1);
        push_upd(10, VF, ev + 12);
        push_upd(12, VD, ev + 14);
        wait_until(ev + 16);
        check("stall_busy_late", 64'(bus.busy), 64'h1);
        wait_until(ev + 17);
        check("stall_end_busy", 64'(bus.busy), 64'h0);
        check("swept_write_pending", 64'(bus.pending), 64'h1);
        rd(2, 64'h0, "swept_idx2_inactive");
        rd(10, VF, "unswept_read10");
        rd(7, VG, "imm_read7");

        // Queued apply: two back-to-back sweeps
        wr(BASE + 16'd0, VH, 1'b0);
        wr(BASE + 16'd15, VI, 1'b0);
        ev = cyc + 1;
        push_upd(0, VH, ev + 1);
        push_upd(2, VC, ev + 3);
        push_upd(15, VI, ev + 16);
        push_upd(1, VJ, ev + 18);
        done_q.push_back(ev + 16);
        done_q.push_back(ev + 32);
        do_apply();
        busy_cnt = 0;
        while (cyc < ev + 32) begin
            if (bus.busy) busy_cnt++;
            if (cyc == ev + 3) begin
                bus.apply = 1'b1;
            end else if (cyc == ev + 7) begin
                bus.address        = BASE + 16'd1;
                bus.data_in        = VJ;
                bus.data_available = 1'b1;
            end
            @(negedge clk);
            idle_inputs();
        end
        check("busy_continuous", 64'(busy_cnt), 64'd32);
        check("queued_end_busy", 64'(bus.busy), 64'h0);
        check("queued_end_pending", 64'(bus.pending), 64'h0);
        rd(1, VJ, "queued_read1");
        rd(15, VI, "queued_read15");

        // Out-of-range writes
        wr(BASE + 16'(NR), 64'h1111_1111_1111_1111, 1'b1);
        check("oor_high_err", 64'(bus.addr_error), 64'h1);
        check("oor_high_strobe", 64'(bus.update_strobe), 64'h0);
        wr(BASE - 16'd1, 64'h2222_2222_2222_2222, 1'b1);
        wr(BASE - 16'd1, 64'h3333_3333_3333_3333, 1'b0);
        check("oor_pending", 64'(bus.pending), 64'h0);
        rd(0, VH, "oor_read0");
        rd(15, VI, "oor_read15");
        repeat (3) @(negedge clk);
        check("err_sticky", 64'(bus.addr_error), 64'h1);

        // Reset mid-sweep
        wr(BASE + 16'd4, VK, 1'b0);
        do_apply();
        @(negedge clk);
        reset = 1'b1;
        #1;
        upd_q.delete();
        done_q.delete();
        check("midrst_busy", 64'(bus.busy), 64'h0);
        check("midrst_err", 64'(bus.addr_error), 64'h0);
        check("midrst_pending", 64'(bus.pending), 64'h0);
        check("midrst_read_data", bus.read_data, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < int'(NR); i++) begin
            rd(i, 64'h0, "midrst_read_all");
        end
        repeat (20) @(negedge clk);
        check("midrst_busy_after", 64'(bus.busy), 64'h0);

        check("upd_q_drained", 64'(upd_q.size()), 64'h0);
        check("done_q_drained", 64'(done_q.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/wide_param_bank.md
# wide_param_bank

Downstream consumer of the 64-bit extended wire-in stage. It captures each `(address, data)` word, with its apply-immediately flag, into a bank of `NUM_REGS` 64-bit parameter registers. Each register has a shadow copy and an active copy. Staged writes collect in the shadow copies, and a sequencer `apply` strobe commits them all to the active copies. Immediate writes go straight to the active copy. Every active-value change is announced on an update strobe so downstream DDS/DAC drivers can reprogram.

## Interface
- `NUM_REGS`, 16: number of parameter registers, power of two, 2..256.
- `ADDR_BASE`, 16'h0000: first bus address mapped to register 0.
- `ADDR_W`, $clog2(NUM_REGS): index width (derived, not overridden).

- `clk` in 1: single clock. Same domain as the wide_clk side of the upstream stage.
- `reset` in 1: asynchronous, active-high.
- `address` in 16: bus address of the incoming word.
- `data_in` in 64: incoming parameter value.
- `data_available` in 1: one-cycle write strobe.
- `apply_immediately` in 1: qualifies `data_available`; when 1, write bypasses the shadow.
- `apply` in 1: one-cycle commit strobe from the pulse sequencer.
- `read_index` in ADDR_W: read-port register index.
- `read_data` out 64: active value of `read_index`, registered.
- `update_strobe` out 1: one-cycle pulse; an active register changed.
- `update_index` out ADDR_W: index of the changed register, valid with `update_strobe`.
- `update_data` out 64: new active value, valid with `update_strobe`.
- `pending` out 1: OR of all per-register pending bits.
- `busy` out 1: commit sweep in progress.
- `apply_done` out 1: one-cycle pulse when a sweep finishes.
- `addr_error` out 1: sticky; set by any out-of-range write, cleared only by reset.

## Operation
- **Decode:** `idx = address - ADDR_BASE`. The write is in range iff `address >= ADDR_BASE` and `idx < NUM_REGS`.
- **Out-of-range writes** change nothing except setting `addr_error`.
- **Staged write** (`data_available & ~apply_immediately`): `shadow[idx] <= data_in`, `pending_bit[idx] <= 1`. No update strobe.
- **Immediate write** (`data_available & apply_immediately`):
  - `shadow[idx]` and `active[idx] <= data_in`; `pending_bit[idx] <= 0`.
  - `update_strobe` fires with `idx` and `data_in`.
- **FSM states:**
  - IDLE: `apply` → SWEEP with `sweep_idx = 0`.
  - SWEEP: each non-stalled cycle processes `sweep_idx`. If `pending_bit[sweep_idx]`: `active <= shadow`, clear the bit, fire `update_strobe`. Then increment.
  - After `NUM_REGS-1` is processed: pulse `apply_done`. Go to SWEEP (idx 0) if an apply is queued, else IDLE.
- **Apply while busy:** an `apply` during SWEEP sets a one-deep `apply_queued` flag. Further applies merge into it. The flag is consumed at sweep end.
- **Stall rule:** in SWEEP, a cycle carrying an in-range immediate write does not process or advance `sweep_idx`. This guarantees at most one update per cycle.
- **Staged write to an unswept index** during SWEEP is committed by the current sweep. A staged write to an already-swept index stays pending.
- **Same-cycle staged write and sweep transfer on index i:** active takes the old shadow. Shadow takes `data_in`. `pending_bit[i]` ends at 1.
- **Read port:** `read_data <= active[read_index]` every cycle.

## Timing
- **Reset values:** all shadow/active 0, pending bits 0, `apply_queued` 0, state IDLE. All outputs are 0.
- **Write latency:** shadow/active are updated at the edge that samples `data_available`. `update_strobe`, `update_index`, `update_data` are registered and high for the following cycle.
- **Read latency:** 1 cycle. A same-edge immediate write to the read index is seen 2 cycles after the write strobe.
- **Commit timing:** `apply` sampled at edge E → `busy` high from E+1. Index k is processed at edge E+1+k (no stalls). Its `update_strobe` is high during cycle E+2+k.
- **Sweep end:** `apply_done` is high during cycle E+1+NUM_REGS. `busy` drops in that same cycle unless a queued apply restarts the sweep.
- **Stalls:** each stall extends the sweep by exactly one cycle.
- **`pending`:** reflects the registered pending bits; it drops the cycle after the last pending bit clears.
- **Reset mid-sweep:** aborts immediately. No `apply_done`, all state returns to reset values.

## Test plan
- **Reset:** assert `reset` mid-traffic → all outputs 0; `read_data` of every index reads 0.
- **Immediate write:** address `ADDR_BASE+3`, data `64'hDEAD_BEEF_0123_4567` → `update_strobe` next cycle with `update_index=3` and that data; `pending=0`; read index 3 returns the value.
- **Staged writes then apply:** staged writes to indices 1 and 5; `apply` at edge E → strobes only in cycles E+3 and E+7; `apply_done` at E+17 (NUM_REGS=16); `pending` 1→0.
- **Write during sweep:** staged write to index 2 at edge E+5 (already swept) → stays pending. Staged write to index 10 at E+5 → committed this sweep. Immediate write at E+6 → sweep stalls once, `apply_done` at E+18.
- **Apply queuing:** `apply` pulses at E and E+4 → two back-to-back sweeps, two `apply_done` pulses, `busy` continuous.
- **Address errors:** write to `ADDR_BASE+NUM_REGS` and to `ADDR_BASE-1` (with `ADDR_BASE`>0) → no register or strobe change; `addr_error` sets and stays 1 until reset.
